// File: rtl/fifo_pop_ctrl_if.sv
// FIFO read-side / downstream bundle for fifo_pop_ctrl.
// Optional pop_cnt member is present only when FIFO_POP_CNT_EN is defined.
interface fifo_pop_ctrl_if #(
  parameter int DATA_W = 6
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_valid;
  logic              pause_in;
  logic              fifo_rd;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              err_out;
`ifdef FIFO_POP_CNT_EN
  logic [7:0]        pop_cnt;
`endif

  modport master (
    input  fifo_empty, fifo_data, fifo_valid, pause_in,
    output fifo_rd, data_out, valid_out, err_out
`ifdef FIFO_POP_CNT_EN
    , output pop_cnt
`endif
  );

  modport slave (
    output fifo_empty, fifo_data, fifo_valid, pause_in,
    input  fifo_rd, data_out, valid_out, err_out
`ifdef FIFO_POP_CNT_EN
    , input pop_cnt
`endif
  );
endinterface

// File: rtl/fifo_pop_ctrl.sv
// FIFO read-side controller with a 2-entry skid absorbing the 1-cycle read latency.
// Optional FIFO_POP_CNT_EN adds an 8-bit wrapping pop counter on the interface.
module fifo_pop_ctrl #(
  parameter int DATA_W     = 6,
  parameter int SKID_DEPTH = 2
) (
  input  logic           clk,
  input  logic           RESET,
  fifo_pop_ctrl_if.master bus
);
  // state | meaning
  // IDLE  | skid empty, no read in flight
  // RUN   | reads and/or pops in progress
  // HOLD  | downstream paused with words held or in flight
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [2:0] DEPTH = 3'(SKID_DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              rd_q;
  logic              ign;
  logic              err;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic [2:0]        inflight;
  logic              pop;
  logic              rd;
  logic              wr;
  logic              overflow;
  logic              unsolicited;
  logic              missing;

  assign pop      = (cnt != 2'd0) & ~bus.pause_in;
  assign inflight = {1'b0, cnt} + {2'b00, rd_q} - {2'b00, pop};
  assign rd       = ~RESET & ~bus.fifo_empty & ~bus.pause_in & (inflight < DEPTH);

  // ign masks a response to a read that was issued before a reset
  assign overflow    = bus.fifo_valid & ~ign & ({1'b0, cnt} == DEPTH) & ~pop;
  assign wr          = bus.fifo_valid & ~ign & ~overflow;
  assign unsolicited = bus.fifo_valid & ~ign & ~rd_q;
  assign missing     = rd_q & ~bus.fifo_valid;
  assign cnt_nxt     = cnt + {1'b0, wr} - {1'b0, pop};

  assign bus.fifo_rd   = rd;
  assign bus.data_out  = mem[rd_ptr];
  assign bus.valid_out = (cnt != 2'd0);
  assign bus.err_out   = err;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      rd_q   <= 1'b0;
      ign    <= 1'b1;
      err    <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      rd_q <= rd;
      ign  <= 1'b0;
      cnt  <= cnt_nxt;
      if (wr) begin
        mem[wr_ptr] <= bus.fifo_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (overflow | unsolicited | missing) err <= 1'b1;
      case (state)
        IDLE: if (rd) state <= RUN;
        RUN: begin
          if (bus.pause_in && ((cnt != 2'd0) || rd_q)) state <= HOLD;
          else if ((cnt_nxt == 2'd0) && !rd_q && !rd) state <= IDLE;
        end
        HOLD: if (!bus.pause_in) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_POP_CNT_EN
  logic [7:0] pop_cnt;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) pop_cnt <= 8'd0;
    else if (pop) pop_cnt <= pop_cnt + 8'd1;
  end

  assign bus.pop_cnt = pop_cnt;
`endif
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl: a small FIFO responder queue plus hand-computed expectations.
// Covers reset, streaming, pause, single-word drain, reset mid-stream, protocol error and the optional pop counter.
module tb_fifo_pop_ctrl;
  logic clk;
  logic RESET;
  int   checks;
  int   errors;
  int   rd_pulses;
  int   vcount;
  logic last_rd;
  logic [5:0] q [$];
  logic [7:0] exp_d [13];

  fifo_pop_ctrl_if #(.DATA_W(6)) bus ();

  fifo_pop_ctrl #(.DATA_W(6), .SKID_DEPTH(2)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample fifo_rd mid-cycle, then model the FIFO's 1-cycle read response.
  task automatic tick();
    logic rd_s;
    @(negedge clk);
    rd_s    = bus.fifo_rd;
    last_rd = rd_s;
    if (rd_s) rd_pulses++;
    @(posedge clk);
    #1;
    if (rd_s && q.size() > 0) begin
      bus.fifo_valid = 1'b1;
      bus.fifo_data  = q.pop_front();
    end else begin
      bus.fifo_valid = 1'b0;
    end
    bus.fifo_empty = (q.size() == 0);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_pulses = 0;
    vcount = 0;
    last_rd = 1'b0;
    RESET = 1'b1;
    bus.fifo_empty = 1'b0;
    bus.fifo_valid = 1'b0;
    bus.fifo_data  = '0;
    bus.pause_in   = 1'b0;
    #2;
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_data",  32'(bus.data_out), 0);
    chk("rst_err",   32'(bus.err_out), 0);
    chk("rst_rd",    32'(bus.fifo_rd), 0);
    bus.fifo_empty = 1'b1;
    @(posedge clk);
    #1 RESET = 1'b0;
    #1;
    tick();

    // streaming 0x01..0x08
    for (int i = 1; i <= 8; i++) q.push_back(6'(i));
    bus.fifo_empty = 1'b0;
    #1;
    rd_pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("stream_rd", 32'(last_rd), 32'(k <= 8));
      chk("stream_valid", 32'(bus.valid_out), 32'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) chk("stream_data", 32'(bus.data_out), 32'(k - 1));
    end
    chk("stream_rd_pulses", 32'(rd_pulses), 8);
    chk("stream_idle", 32'(dut.state), 0);
    chk("stream_err", 32'(bus.err_out), 0);

    // pause for 5 cycles after the 2nd word appears
    exp_d = '{8'h00, 8'h10, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11,
              8'h12, 8'h13, 8'h14, 8'h15, 8'h00};
    for (int i = 0; i < 6; i++) q.push_back(6'(8'h10 + i));
    bus.fifo_empty = 1'b0;
    #1;
    rd_pulses = 0;
    for (int k = 1; k <= 13; k++) begin
      bus.pause_in = (k >= 4 && k <= 8);
      tick();
      chk("pause_rd", 32'(last_rd), 32'((k <= 3) || (k >= 9 && k <= 11)));
      chk("pause_valid", 32'(bus.valid_out), 32'(k >= 2 && k <= 12));
      if (k >= 2 && k <= 12) chk("pause_data", 32'(bus.data_out), 32'(exp_d[k-1]));
    end
    bus.pause_in = 1'b0;
    chk("pause_rd_pulses", 32'(rd_pulses), 6);
    chk("pause_idle", 32'(dut.state), 0);
    chk("pause_err", 32'(bus.err_out), 0);

    // single word drain
    q.push_back(6'h3F);
    bus.fifo_empty = 1'b0;
    #1;
    rd_pulses = 0;
    vcount = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.valid_out) begin
        vcount++;
        chk("empty_data", 32'(bus.data_out), 32'h3F);
      end
      chk("empty_rd_low", 32'(bus.fifo_rd), 0);
    end
    chk("empty_rd_pulses", 32'(rd_pulses), 1);
    chk("empty_valid_cycles", 32'(vcount), 1);
    chk("empty_idle", 32'(dut.state), 0);

    // reset mid-stream with a full skid and a read about to issue
    for (int i = 0; i < 6; i++) q.push_back(6'(8'h21 + i));
    bus.fifo_empty = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      bus.pause_in = (k == 4);
      tick();
    end
    chk("mid_valid", 32'(bus.valid_out), 1);
    chk("mid_data", 32'(bus.data_out), 32'h22);
    bus.pause_in = 1'b0;
    #1;
    chk("mid_rd", 32'(bus.fifo_rd), 1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.valid_out), 0);
    chk("mid_rst_data",  32'(bus.data_out), 0);
    chk("mid_rst_rd",    32'(bus.fifo_rd), 0);
    chk("mid_rst_err",   32'(bus.err_out), 0);
    q.delete();
    bus.fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    bus.fifo_valid = 1'b1;
    bus.fifo_data  = 6'h23;
    @(posedge clk);
    #1 bus.fifo_valid = 1'b0;
    #1;
    chk("stale_err", 32'(bus.err_out), 0);
    chk("stale_valid", 32'(bus.valid_out), 0);
    tick();
    chk("stale_err_later", 32'(bus.err_out), 0);

    // unsolicited data
    bus.fifo_valid = 1'b1;
    bus.fifo_data  = 6'h05;
    @(posedge clk);
    #1 bus.fifo_valid = 1'b0;
    #1;
    chk("err_set", 32'(bus.err_out), 1);
    for (int k = 0; k < 3; k++) tick();
    chk("err_sticky", 32'(bus.err_out), 1);
    RESET = 1'b1;
    #1;
    chk("err_cleared", 32'(bus.err_out), 0);
    @(posedge clk);
    #1 RESET = 1'b0;
    #1;
    tick();

`ifdef FIFO_POP_CNT_EN
    chk("popcnt_reset", 32'(bus.pop_cnt), 0);
    for (int i = 0; i < 260; i++) q.push_back(6'(i));
    bus.fifo_empty = 1'b0;
    #1;
    for (int k = 0; k < 270; k++) tick();
    chk("popcnt_wrap", 32'(bus.pop_cnt), 4);
    chk("popcnt_err", 32'(bus.err_out), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_pop_ctrl.md
Name: fifo_pop_ctrl

Overview:
- Read-side controller for one `fifo` instance; owns the FIFO's `fifo_rd` strobe.
- Drains the FIFO whenever it is non-empty and the downstream stage is not paused.
- Absorbs the memory's 1-cycle read latency with a 2-entry skid buffer, so no word is lost or duplicated when downstream pause toggles.
- Sits between the FIFO and the next pipeline stage (arbiter/demux) and presents a valid/pause stream.

Parameters:
- DATA_W, 6, width of the FIFO data word.
- SKID_DEPTH, 2, skid-buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  system clock, all state on posedge.
- RESET  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO read data; valid when fifo_valid=1.
- fifo_valid  input  1  FIFO read-data valid; arrives exactly 1 cycle after fifo_rd.
- pause_in  input  1  downstream pause; 1 = word not taken this cycle.
- fifo_rd  output  1  FIFO read strobe (combinational).
- data_out  output  DATA_W  head-of-skid word.
- valid_out  output  1  data_out holds a valid word.
- err_out  output  1  protocol error, sticky until RESET.

Behaviour:
- Reset: any cycle RESET=1 asynchronously clears the following.
  - Skid count and pointers, rd_q (registered fifo_rd), FSM to IDLE.
  - data_out=0, valid_out=0, err_out=0.
  - fifo_rd is forced to 0 while RESET=1.
  - Reset mid-operation discards in-flight and buffered words; a fifo_valid arriving the cycle after RESET deasserts is ignored (not an error).
- Pop definition: pop = valid_out & ~pause_in. The word at head is consumed at that clock edge.
- Read issue (combinational): fifo_rd = ~fifo_empty & ~pause_in & (skid_cnt + rd_q - pop < 2).
  - Gives one word per cycle in steady state: skid_cnt=1, rd_q=1, pop=1.
- Capture: when fifo_valid=1, fifo_data is written at the skid tail on that edge.
  - Simultaneous capture and pop: count unchanged, head advances.
  - Capture into an empty skid with pop=0: word appears on data_out the next cycle.
  - No bypass path; latency from fifo_rd to valid_out is 2 cycles.
- Skid buffer:
  - 2 entries, 1-bit wrapping read/write pointers, 2-bit count (0..2).
  - data_out = entry[rd_ptr]; valid_out = (skid_cnt != 0). Both are driven from registered state.
- FSM (2-bit encoding):
  - IDLE: skid_cnt=0 and rd_q=0. Goes to RUN when fifo_rd=1.
  - RUN: reads and/or pops in progress.
    - Goes to HOLD when pause_in=1 and (skid_cnt+rd_q)>0.
    - Goes to IDLE when the next-state skid_cnt=0, rd_q=0 and fifo_rd=0.
  - HOLD: fifo_rd=0 and data_out stable. Returns to RUN when pause_in=0.
  - The state is informational for debug/coverage; issue logic uses the equations above.
- Errors (err_out set next edge, sticky):
  - fifo_valid=1 when rd_q=0 (unsolicited data).
  - fifo_valid=1 with skid_cnt=2 and pop=0 (overflow); the word is dropped and the skid is unchanged.
  - rd_q=1 but fifo_valid=0 (missing response).
- Boundary conditions:
  - fifo_empty=1 forces fifo_rd=0, so the FIFO never sees a read while empty.
  - pause_in rising while a read is in flight: the word lands in the skid. At most 2 words are held, so no loss.
  - Pointer wrap 1→0 is natural 1-bit overflow.

Optional Feature:
- Macro: FIFO_POP_CNT_EN.
- When defined: adds output pop_cnt [7:0].
  - Increments on every pop and wraps 255→0.
  - Reset to 0 by RESET.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: RESET=1 mid-stream with skid_cnt=2 -> same cycle valid_out=0, data_out=0, fifo_rd=0, err_out=0; after release the stale fifo_valid is ignored and err_out stays 0.
- Streaming: FIFO preloaded with 0x01..0x08, pause_in=0.
  - fifo_rd high 8 consecutive cycles.
  - valid_out high 8 consecutive cycles starting 2 cycles after the first fifo_rd.
  - data_out 0x01..0x08 in order.
- Pause: stream 0x10..0x15 and hold pause_in=1 for 5 cycles after the 2nd word appears.
  - fifo_rd=0 during the pause.
  - skid holds at most 2 words.
  - After release, output continues 0x12.. with no gap, loss or duplicate.
- Empty: FIFO holds 1 word (0x3F).
  - Exactly one fifo_rd pulse.
  - valid_out for 1 cycle with data_out=0x3F.
  - FSM ends in IDLE; fifo_rd stays 0 while fifo_empty=1.
- Error: inject fifo_valid=1 with no prior fifo_rd -> err_out=1 next cycle and stays 1 until RESET.
- FIFO_POP_CNT_EN defined: 260 words popped -> pop_cnt=4.
